// File: rtl/exe_commit_buffer.sv
// In-order commit buffer: retires execute results to the register file, redirects fetch on taken branches.
// Retire is combinational from the head entry; a retired taken branch squashes all younger entries.
module exe_commit_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_rd_wen,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rd_data,
  input  logic            in_is_branch,
  input  logic            in_b_flag,
  input  logic [XLEN-1:0] in_br_target,
  output logic            commit_valid,
  input  logic            commit_ready,
  output logic [XLEN-1:0] commit_pc,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  input  logic [4:0]      fwd_raddr,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic [63:0]     instret
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            is_branch;
    logic            b_flag;
    logic [XLEN-1:0] br_target;
  } entry_t;

  entry_t          ent_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     instret_q, instret_d;

  entry_t head_ent;
  logic   fire;
  logic   enq;
  logic   taken;

  assign head_ent       = ent_q[head_q];
  assign commit_valid   = (count_q != '0);
  assign fire           = commit_valid & commit_ready;
  assign taken          = fire & head_ent.is_branch & head_ent.b_flag;
  assign redirect_valid = taken;
  assign redirect_pc    = head_ent.br_target;
  assign flush          = taken;
  assign in_ready       = (count_q < CW'(DEPTH)) & ~taken;
  assign enq            = in_valid & in_ready;

  assign commit_pc = head_ent.pc;
  assign rf_wen    = fire & head_ent.rd_wen & (head_ent.rd_addr != 5'd0);
  assign rf_waddr  = head_ent.rd_addr;
  assign rf_wdata  = head_ent.rd_data;
  assign instret   = instret_q;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    instret_d = instret_q + {63'd0, fire};
    if (taken) begin
      // Squash everything behind the branch; empty buffer restarts just past it.
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (fire) head_d = head_q + PW'(1);
      if (enq)  tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(fire);
    end
  end

  // Oldest-to-youngest scan so the youngest match wins; in-flight enqueue is not visible.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && ent_q[idx].rd_wen &&
          (ent_q[idx].rd_addr == fwd_raddr) && (fwd_raddr != 5'd0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_q[idx].rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      instret_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      instret_q <= instret_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      ent_q[tail_q] <= '{pc:        in_pc,
                         rd_wen:    in_rd_wen,
                         rd_addr:   in_rd_addr,
                         rd_data:   in_rd_data,
                         is_branch: in_is_branch,
                         b_flag:    in_b_flag,
                         br_target: in_br_target};
    end
  end

endmodule

// File: tb/tb_exe_commit_buffer.sv
// Directed bench for exe_commit_buffer with hand-computed expectations.
module tb_exe_commit_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic        in_rd_wen;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_rd_data;
  logic        in_is_branch;
  logic        in_b_flag;
  logic [63:0] in_br_target;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  exe_commit_buffer #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rd_wen(in_rd_wen), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .in_is_branch(in_is_branch), .in_b_flag(in_b_flag), .in_br_target(in_br_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic wen,
                       input logic [4:0] rd, input logic [63:0] data,
                       input logic br, input logic flag, input logic [63:0] tgt);
    in_valid     = v;
    in_pc        = pc;
    in_rd_wen    = wen;
    in_rd_addr   = rd;
    in_rd_data   = data;
    in_is_branch = br;
    in_b_flag    = flag;
    in_br_target = tgt;
  endtask

  // Advance one rising edge, then settle inputs/outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    commit_ready = 1'b0;
    fwd_raddr = 5'd5;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_commit_valid", 64'(commit_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_instret", instret, 0);
    chk("rst_fwd_hit", 64'(fwd_hit), 0);
    chk("rst_redirect", 64'(redirect_valid), 0);
    chk("rst_flush", 64'(flush), 0);
    chk("rst_rf_wen", 64'(rf_wen), 0);

    // Single ALU result, commit_ready high
    commit_ready = 1'b1;
    drive(1, 64'h8000_0000, 1, 5'd5, 64'h1234, 0, 0, 0);
    #1;
    chk("enq_no_bypass_cv", 64'(commit_valid), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_commit_valid", 64'(commit_valid), 1);
    chk("t1_commit_pc", commit_pc, 64'h8000_0000);
    chk("t1_rf_wen", 64'(rf_wen), 1);
    chk("t1_rf_waddr", 64'(rf_waddr), 5);
    chk("t1_rf_wdata", rf_wdata, 64'h1234);
    step();
    chk("t1_instret", instret, 1);
    chk("t1_empty", 64'(commit_valid), 0);

    // Fill with commit stalled; third request refused
    commit_ready = 1'b0;
    drive(1, 64'h8000_0004, 1, 5'd7, 64'hAAAA, 0, 0, 0);
    step();
    drive(1, 64'h8000_0008, 1, 5'd7, 64'hBBBB, 0, 0, 0);
    #1;
    chk("fill_ready2", 64'(in_ready), 1);
    step();
    drive(1, 64'h8000_000C, 1, 5'd7, 64'hCCCC, 0, 0, 0);
    fwd_raddr = 5'd7;
    #1;
    chk("full_in_ready", 64'(in_ready), 0);
    chk("fwd_young_hit", 64'(fwd_hit), 1);
    chk("fwd_young_data", fwd_data, 64'hBBBB);
    fwd_raddr = 5'd3;
    #1;
    chk("fwd_miss", 64'(fwd_hit), 0);
    // Retire while full: still no enqueue
    commit_ready = 1'b1;
    #1;
    chk("full_fire_in_ready", 64'(in_ready), 0);
    chk("drain_a_pc", commit_pc, 64'h8000_0004);
    chk("drain_a_data", rf_wdata, 64'hAAAA);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_b_pc", commit_pc, 64'h8000_0008);
    chk("drain_b_data", rf_wdata, 64'hBBBB);
    step();
    chk("drain_empty", 64'(commit_valid), 0);
    chk("drain_instret", instret, 3);

    // rd = x0 never written
    commit_ready = 1'b0;
    drive(1, 64'h8000_0010, 1, 5'd0, 64'hFFFF, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    fwd_raddr = 5'd0;
    #1;
    chk("x0_fwd_hit", 64'(fwd_hit), 0);
    commit_ready = 1'b1;
    #1;
    chk("x0_commit_valid", 64'(commit_valid), 1);
    chk("x0_rf_wen", 64'(rf_wen), 0);
    step();
    chk("x0_instret", instret, 4);

    // Taken branch at head with a younger ALU entry
    commit_ready = 1'b0;
    drive(1, 64'h8000_0020, 0, 5'd0, 0, 1, 1, 64'h8000_0100);
    step();
    drive(1, 64'h8000_0024, 1, 5'd9, 64'h99, 0, 0, 0);
    step();
    drive(1, 64'h8000_0028, 1, 5'd10, 64'h77, 0, 0, 0);
    fwd_raddr = 5'd9;
    #1;
    chk("br_fwd_young", fwd_data, 64'h99);
    commit_ready = 1'b1;
    #1;
    chk("br_redirect", 64'(redirect_valid), 1);
    chk("br_flush", 64'(flush), 1);
    chk("br_redirect_pc", redirect_pc, 64'h8000_0100);
    chk("br_in_ready", 64'(in_ready), 0);
    chk("br_rf_wen", 64'(rf_wen), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_post_cv", 64'(commit_valid), 0);
    chk("br_post_redirect", 64'(redirect_valid), 0);
    chk("br_post_flush", 64'(flush), 0);
    chk("br_post_fwd", 64'(fwd_hit), 0);
    chk("br_instret", instret, 5);
    step();
    chk("br_young_gone", instret, 5);

    // Not-taken branch
    drive(1, 64'h8000_0030, 0, 5'd0, 0, 1, 0, 64'h8000_0200);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("nt_commit_valid", 64'(commit_valid), 1);
    chk("nt_redirect", 64'(redirect_valid), 0);
    chk("nt_rf_wen", 64'(rf_wen), 0);
    step();
    chk("nt_instret", instret, 6);

    // Simultaneous enqueue/retire over 8 cycles: pointers wrap, order preserved
    for (int i = 0; i < 8; i++) begin
      drive(1, 64'h8000_1000 + 64'(4 * i), 1, 5'(i + 1), 64'(i + 100), 0, 0, 0);
      #1;
      chk("wrap_in_ready", 64'(in_ready), 1);
      if (i > 0) chk("wrap_commit_pc", commit_pc, 64'h8000_1000 + 64'(4 * (i - 1)));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_last_pc", commit_pc, 64'h8000_101C);
    chk("wrap_last_data", rf_wdata, 64'd107);
    step();
    chk("wrap_instret", instret, 14);

    // Reset with two entries buffered
    commit_ready = 1'b0;
    drive(1, 64'h8000_2000, 1, 5'd11, 64'h11, 0, 0, 0);
    step();
    drive(1, 64'h8000_2004, 1, 5'd12, 64'h22, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    commit_ready = 1'b1;
    #1;
    chk("mrst_commit_valid", 64'(commit_valid), 0);
    chk("mrst_instret", instret, 0);
    chk("mrst_in_ready", 64'(in_ready), 1);
    step();
    chk("mrst_no_retire", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
